streamer_vfpu_credit: RTL
=========================

# streamer_vfpu_credit

Next-generation VFPU streamer: joins `NB_OPERANDS` HWPE operand streams, issues one operand tuple per cycle to an external pipelined VFPU, and buffers results in a `FIFO_DEPTH` result FIFO. Credit-based issue guarantees no result is lost under result-stream backpressure. A length counter bounds each job. Sits between the HWPE source/sink streamers and the `vfpu` datapath in the VFPU accelerator.

## Interface
- `DATA_WIDTH`, 32: operand/result width; multiple of 8.
- `NB_OPERANDS`, 2: operand streams joined per issue; range 1..4.
- `FIFO_DEPTH`, 4: result FIFO entries; power of 2, ≥2; also the maximum outstanding results.
- `LEN_WIDTH`, 16: width of the job length.
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous job abort.
- `start_i`  in  1  starts a job; sampled in IDLE only.
- `len_i`  in  LEN_WIDTH  number of elements; sampled with `start_i`.
- `busy_o`  out  1  high in RUN or DRAIN.
- `done_o`  out  1  one-cycle pulse at job completion.
- `err_o`  out  1  sticky; set by `fu_done_i` with zero outstanding.
- `flags_acc_o`  out  flags_vfpu_t  sticky bitwise OR of `fu_flags_i` over the job.
- `operand_streams_sink[NB_OPERANDS]`  sink  hwpe_stream_intf_stream  operand streams.
- `result_stream_source`  source  hwpe_stream_intf_stream  result stream.
- `fu_operands_o`  out  NB_OPERANDS*DATA_WIDTH  operand k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- `fu_valid_o`  out  1  issue strobe to the VFPU.
- `fu_ready_i`  in  1  VFPU can accept an issue.
- `fu_result_i`  in  DATA_WIDTH  VFPU result.
- `fu_flags_i`  in  flags_vfpu_t  flags qualified by `fu_done_i`.
- `fu_done_i`  in  1  result valid, one cycle per result.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `start_i` with `len_i`>0 → RUN.
  - Loads `len`, zeroes `issued`, `returned` and `flags_acc_o`.
  - `start_i` with `len_i`=0 → `done_o` pulse next cycle, stays IDLE.
- **Issue condition:** `issue` = RUN ∧ all sink `valid` ∧ `fu_ready_i` ∧ (`outstanding` + `fifo_count`) < `FIFO_DEPTH`.
- **Issue outputs:** `fu_valid_o` = `issue`. Every sink `ready` = `issue`, so all sinks are consumed together. `fu_operands_o` is the sink data, combinational.
- **Counters on issue:** `issued`++ and `outstanding`++.
- **RUN exit:** when `issued` reaches `len` → DRAIN.
- **Result return (`fu_done_i`):**
  - Push `fu_result_i` into the FIFO.
  - `outstanding`--, `returned`++.
  - `flags_acc_o` |= `fu_flags_i`.
  - If `outstanding`=0: no push, `err_o` set.
- **Result stream:** `data` = FIFO head, `valid` = FIFO non-empty, `strb` = all ones (DATA_WIDTH/8 bits). Pop on `valid` ∧ `ready`.
- **DRAIN exit:** when `returned`=`len` and FIFO empty → `done_o` pulse, → IDLE.
- **Ignored inputs:**
  - `start_i` in RUN or DRAIN.
  - Sink data in IDLE/DRAIN (`ready`=0).
- **`clear_i`:**
  - Zeroes FIFO, counters and FSM (→ IDLE); no `done_o`.
  - `flags_acc_o` and `err_o` are retained.
  - Results returning after a clear count as spurious and set `err_o`.
- **`rst_i`:** everything to reset values, including `err_o` and `flags_acc_o`.

## Timing
- **Reset values:** `busy_o`=0, `done_o`=0, `err_o`=0, `flags_acc_o`=0, `fu_valid_o`=0, sink `ready`=0, source `valid`=0.
- **Issue latency:** zero cycles from a sink handshake; issue occurs the same cycle.
- **Result latency:** `fu_done_i` in cycle u → source `valid` in cycle u+1 (registered FIFO, no bypass).
- **Throughput:** one issue per cycle when `FIFO_DEPTH` exceeds the VFPU latency and the sink never stalls.
- **Simultaneous push and pop:** allowed in the same cycle, including when the FIFO is full; occupancy is unchanged. The credit rule makes overflow impossible.
- **Outstanding counter:** simultaneous issue and return leave it unchanged.
- **`done_o`:** asserted the cycle after the final pop. `busy_o` falls in that same cycle.
- **Counters:**
  - `issued` and `returned` are LEN_WIDTH wide and never wrap; `len` max is 2^LEN_WIDTH−1.
  - `outstanding` and `fifo_count` are $clog2(FIFO_DEPTH)+1 wide.
- **Priority:** `rst_i` > `clear_i` > all else. `clear_i` with `start_i` in the same cycle → IDLE; the start is dropped.

## Test plan
- **Basic job:** NB_OPERANDS=2, FIFO_DEPTH=4, VFPU model with latency 3, `len`=8, operands A=i, B=2i, sink always valid, result always ready → 8 results equal to the model output, in order. `done_o` fires once, the cycle after the 8th pop.
- **Backpressure:** same setup, result `ready`=0 for 20 cycles → at most 4 issues (`outstanding`+`fifo_count` ≤ 4). No result is lost. Issue resumes the cycle after the first pop.
- **Join stall:** sink 1 `valid` toggling every other cycle → no handshake on either sink while sink 1 is low. Operand pairing is preserved.
- **Edge lengths:** `len`=0 → `done_o` one cycle after `start_i`, no `fu_valid_o`. `len`=1 → exactly one issue and one result.
- **Mid-job clear:** `clear_i` in RUN after 3 issues → `busy_o`=0 next cycle, FIFO empty, no `done_o`. A late `fu_done_i` sets `err_o`; `rst_i` clears `err_o`.
- **Flags:** `fu_flags_i` overflow bit on result 2 only → `flags_acc_o` overflow bit stays 1 through `done_o` and is cleared by the next `start_i`.

Source files
------------

// File: rtl/streamer_vfpu_credit_if.sv
// Shared VFPU flag type and the HWPE-style valid/ready stream interface
// used for the operand and result streams of streamer_vfpu_credit.
package vfpu_pkg;
    // IEEE exception flags in the usual NV/DZ/OF/UF/NX order (overflow is bit 2).
    typedef struct packed {
        logic invalid;
        logic div_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } flags_vfpu_t;
endpackage

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/streamer_vfpu_credit.sv
// Joins NB_OPERANDS operand streams into one issue per cycle towards a
// pipelined VFPU and buffers its results in a small FIFO. Issue is gated by a
// credit check (in-flight results + buffered results < FIFO_DEPTH) so a result
// always has a free slot, no matter how long the result stream stalls.
module streamer_vfpu_credit
    import vfpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NB_OPERANDS = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clear_i,
    input  logic                            start_i,
    input  logic [LEN_WIDTH-1:0]            len_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output flags_vfpu_t                     flags_acc_o,
    hwpe_stream_intf_stream.slave           operand_streams_sink [NB_OPERANDS],
    hwpe_stream_intf_stream.master          result_stream_source,
    output logic [NB_OPERANDS*DATA_WIDTH-1:0] fu_operands_o,
    output logic                            fu_valid_o,
    input  logic                            fu_ready_i,
    input  logic [DATA_WIDTH-1:0]           fu_result_i,
    input  flags_vfpu_t                     fu_flags_i,
    input  logic                            fu_done_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   issued;
    logic [LEN_WIDTH-1:0]   returned;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          fifo_count;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];

    logic [NB_OPERANDS-1:0] sink_valid;
    logic [CW:0]            credit_used;
    logic                   issue;
    logic                   ret_ok;
    logic                   ret_spurious;
    logic                   pop;
    logic [LEN_WIDTH-1:0]   issued_nxt;
    logic [LEN_WIDTH-1:0]   returned_nxt;
    logic [CW-1:0]          count_nxt;

    // All sinks share one ready so operands of a tuple are always consumed together.
    for (genvar k = 0; k < NB_OPERANDS; k++) begin : g_sink
        assign sink_valid[k]                              = operand_streams_sink[k].valid;
        assign fu_operands_o[k*DATA_WIDTH +: DATA_WIDTH]  = operand_streams_sink[k].data;
        assign operand_streams_sink[k].ready              = issue;
    end

    assign credit_used  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue        = (state == RUN) && (&sink_valid) && fu_ready_i &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
    assign fu_valid_o   = issue;

    // A return with nothing in flight belongs to an aborted job (or is bogus).
    assign ret_ok       = fu_done_i && (outstanding != '0);
    assign ret_spurious = fu_done_i && (outstanding == '0);
    assign pop          = (fifo_count != '0) && result_stream_source.ready;

    assign issued_nxt   = issued + LEN_WIDTH'(issue);
    assign returned_nxt = returned + LEN_WIDTH'(ret_ok);
    assign count_nxt    = fifo_count + CW'(ret_ok) - CW'(pop);

    assign busy_o                    = (state != IDLE);
    assign result_stream_source.valid = (fifo_count != '0);
    assign result_stream_source.data  = fifo_mem[rd_ptr];
    assign result_stream_source.strb  = '1;

    // Job FSM with its counters and sticky status; clear keeps err/flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            len_q       <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            flags_acc_o <= '0;
        end else if (clear_i) begin
            state       <= IDLE;
            len_q       <= '0;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o      <= 1'b0;
            issued      <= issued_nxt;
            returned    <= returned_nxt;
            outstanding <= outstanding + CW'(issue) - CW'(ret_ok);
            if (ret_spurious) begin
                err_o <= 1'b1;
            end
            if (ret_ok) begin
                flags_acc_o <= flags_vfpu_t'(flags_acc_o | fu_flags_i);
            end
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q       <= len_i;
                        issued      <= '0;
                        returned    <= '0;
                        flags_acc_o <= '0;
                        if (len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issued_nxt == len_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Look at next-cycle values so done lands right after the last pop.
                    if ((returned_nxt == len_q) && (count_nxt == '0)) begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result FIFO occupancy and pointers; push and pop may coincide even when full.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (ret_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= count_nxt;
        end
    end

    // Result storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk_i) begin
        if (ret_ok) begin
            fifo_mem[wr_ptr] <= fu_result_i;
        end
    end

endmodule
